// File: rtl/pulse_gen_pkg.sv
// ============================================================================
//  Module      : pulse_gen_pkg
//  Description : Shared state encoding and default widths for pulse_train_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_gen_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int NUM_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } pulse_gen_state_t;

endpackage : pulse_gen_pkg

`default_nettype wire

// File: rtl/pulse_rise_det.sv
// ============================================================================
//  Module      : pulse_rise_det
//  Description : Rising-edge strobe; previous value resets to 1 so a level
//                already high when reset releases is not seen as an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_rise_det (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic sig_i,
    output logic rise_o
);

    logic r_prev;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= sig_i;
        end
    end

    assign rise_o = sig_i & ~r_prev;

endmodule : pulse_rise_det

`default_nettype wire

// File: rtl/pulse_train_gen.sv
// ============================================================================
//  Module      : pulse_train_gen
//  Description : Programmable pulse-train generator (width/period/count) with
//                stop, config rejection and done/err strobes.
//                Define PULSE_TRAIN_GEN_LED_EN to add the led_busy_n_o output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [NUM_W-1:0] count_i,
`ifdef PULSE_TRAIN_GEN_LED_EN
    output logic             led_busy_n_o,
`endif
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [NUM_W-1:0] c_rem_one = NUM_W'(1);

    pulse_gen_state_t r_state, w_state;
    logic [CNT_W-1:0] r_width, w_width;
    logic [CNT_W-1:0] r_period, w_period;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [NUM_W-1:0] r_rem, w_rem;
    logic             r_cont, w_cont;
    logic             r_pulse, w_pulse;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_err, w_err;
    logic             w_start;

    pulse_rise_det u_start_det (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .sig_i     (start_i),
        .rise_o    (w_start)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= IDLE;
            r_width  <= '0;
            r_period <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_cont   <= 1'b0;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_width  <= w_width;
            r_period <= w_period;
            r_cnt    <= w_cnt;
            r_rem    <= w_rem;
            r_cont   <= w_cont;
            r_pulse  <= w_pulse;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_err    <= w_err;
        end
    end

    // r_cnt numbers the cycles of the current period from 1, so it never
    // exceeds r_period and cannot wrap even at the maximum legal period.
    always_comb begin
        w_state  = r_state;
        w_width  = r_width;
        w_period = r_period;
        w_cnt    = r_cnt;
        w_rem    = r_rem;
        w_cont   = r_cont;
        w_pulse  = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start && !stop_i) begin
                    if ((width_i == '0) || (width_i >= period_i)) begin
                        w_err = 1'b1;
                    end else begin
                        w_width  = width_i;
                        w_period = period_i;
                        w_rem    = count_i;
                        w_cont   = (count_i == '0);
                        w_cnt    = c_cnt_one;
                        w_state  = HIGH;
                        w_pulse  = 1'b1;
                        w_busy   = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (stop_i) begin
                    w_state = DONE;
                    w_done  = 1'b1;
                end else begin
                    w_busy = 1'b1;
                    w_cnt  = r_cnt + c_cnt_one;
                    if (r_cnt >= r_width) begin
                        w_state = LOW;
                    end else begin
                        w_pulse = 1'b1;
                    end
                end
            end
            LOW: begin
                if (stop_i) begin
                    w_state = DONE;
                    w_done  = 1'b1;
                end else if (r_cnt >= r_period) begin
                    if (!r_cont) begin
                        w_rem = r_rem - c_rem_one;
                    end
                    if (r_cont || (r_rem != c_rem_one)) begin
                        w_state = HIGH;
                        w_cnt   = c_cnt_one;
                        w_pulse = 1'b1;
                        w_busy  = 1'b1;
                    end else begin
                        w_state = DONE;
                        w_done  = 1'b1;
                    end
                end else begin
                    w_busy = 1'b1;
                    w_cnt  = r_cnt + c_cnt_one;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign pulse_o = r_pulse;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign err_o   = r_err;

`ifdef PULSE_TRAIN_GEN_LED_EN
    logic r_led_n;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_led_n <= 1'b1;
        end else begin
            r_led_n <= ~w_busy;
        end
    end

    assign led_busy_n_o = r_led_n;
`endif

endmodule : pulse_train_gen

`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
// ============================================================================
//  Module      : tb_pulse_train_gen
//  Description : Self-checking bench for pulse_train_gen with a cycle-offset
//                reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_train_gen;

    localparam int CW = 8;
    localparam int NW = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic [CW-1:0] width   = '0;
    logic [CW-1:0] period  = '0;
    logic [NW-1:0] count   = '0;
    logic          pulse, busy, done, err;
`ifdef PULSE_TRAIN_GEN_LED_EN
    logic          led_n;
`endif

    always #5 clk = ~clk;

    pulse_train_gen #(.CNT_W(CW), .NUM_W(NW)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .start_i      (start),
        .stop_i       (stop),
        .width_i      (width),
        .period_i     (period),
        .count_i      (count),
`ifdef PULSE_TRAIN_GEN_LED_EN
        .led_busy_n_o (led_n),
`endif
        .pulse_o      (pulse),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a train started at edge k is described by the offset
    // t (t=1 is the first cycle after k); pulse is high for the first w cycles
    // of each p-cycle period, the train lasts n*p cycles, done follows it.
    bit     m_active  = 1'b0;
    bit     m_prev    = 1'b1;
    bit     m_cont    = 1'b0;
    bit     m_rise    = 1'b0;
    bit     m_was_done = 1'b0;
    longint m_t = 0, m_w = 0, m_p = 1, m_n = 0;
    bit     e_pulse = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_prev   = 1'b1;
            e_pulse  = 1'b0;
            e_busy   = 1'b0;
            e_done   = 1'b0;
            e_err    = 1'b0;
        end else begin
            m_rise     = start && !m_prev;
            m_prev     = start;
            m_was_done = e_done;
            e_done     = 1'b0;
            e_err      = 1'b0;
            if (m_active) begin
                if (stop) begin
                    m_active = 1'b0;
                    e_done   = 1'b1;
                end else begin
                    m_t++;
                    if (!m_cont && (m_t > m_n * m_p)) begin
                        m_active = 1'b0;
                        e_done   = 1'b1;
                    end
                end
            end else if (!m_was_done && m_rise && !stop) begin
                if ((width == 0) || (width >= period)) begin
                    e_err = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_t      = 1;
                    m_w      = longint'(width);
                    m_p      = longint'(period);
                    m_n      = longint'(count);
                    m_cont   = (count == 0);
                end
            end
            e_busy  = m_active;
            e_pulse = m_active && (((m_t - 1) % m_p) < m_w);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model pulse_o", pulse, e_pulse);
            check("model busy_o",  busy,  e_busy);
            check("model done_o",  done,  e_done);
            check("model err_o",   err,   e_err);
        end
    end

    task automatic cfg(input int w, input int p, input int c);
        width  = CW'(w);
        period = CW'(p);
        count  = NW'(c);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int highs, dones, rises, busies;
    logic last_pulse;
    int err_w [3] = '{0, 10, 255};
    int err_p [3] = '{10, 10, 255};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pulse_o", pulse, 0);
        check("reset busy_o",  busy,  0);
        check("reset done_o",  done,  0);
        check("reset err_o",   err,   0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (3) @(negedge clk);

        // width 3, period 10, count 2: high at offsets 1-3 and 11-13, done at 21
        cfg(3, 10, 2);
        start = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            check("s1 pulse_o", pulse, ((i >= 1 && i <= 3) || (i >= 11 && i <= 13)) ? 1 : 0);
            check("s1 busy_o",  busy,  (i <= 20) ? 1 : 0);
            check("s1 done_o",  done,  (i == 21) ? 1 : 0);
            if (i == 1) start = 1'b0;
        end

        // rejected configurations
        for (int k = 0; k < 3; k++) begin
            cfg(err_w[k], err_p[k], 1);
            start = 1'b1;
            @(negedge clk);
            check("err strobe", err, 1);
            check("err busy_o", busy, 0);
            start = 1'b0;
            @(negedge clk);
            check("err single cycle", err, 0);
            check("err pulse_o", pulse, 0);
            @(negedge clk);
        end

        // continuous 50% train, then stop while high
        cfg(2, 4, 0);
        start = 1'b1;
        highs = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (pulse === 1'b1) highs++;
            start = 1'b0;
        end
        check("cont high cycles in 12", highs, 6);
        for (int k = 0; k < 10 && pulse !== 1'b1; k++) @(negedge clk);
        check("stop setup pulse_o", pulse, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop pulse_o", pulse, 0);
        check("stop done_o",  done,  1);
        check("stop busy_o",  busy,  0);
        @(negedge clk);
        check("stop done single", done, 0);
        repeat (2) @(negedge clk);

        // start held 100 cycles with count 1 -> one pulse
        cfg(2, 5, 1);
        start = 1'b1;
        rises = 0; highs = 0; last_pulse = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pulse === 1'b1) highs++;
            if (pulse === 1'b1 && last_pulse === 1'b0) rises++;
            last_pulse = pulse;
        end
        check("held start pulses", rises, 1);
        check("held start high cycles", highs, 2);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // second start mid-train and input changes are ignored
        cfg(3, 6, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        highs = (pulse === 1'b1) ? 1 : 0;
        dones = 0;
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            if (i == 4) begin
                start = 1'b1;
                cfg(1, 2, 5);
            end
            if (i == 6) start = 1'b0;
            if (pulse === 1'b1) highs++;
            if (done === 1'b1) dones++;
        end
        check("mid-start high cycles", highs, 6);
        check("mid-start done count", dones, 1);

        // start and stop together in idle
        cfg(2, 4, 1);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("start+stop busy_o", busy, 0);
        check("start+stop err_o",  err,  0);
        @(negedge clk);
        check("start+stop no retrigger", busy, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // largest legal period for the counter width
        cfg(254, 255, 1);
        start = 1'b1;
        highs = 0; busies = 0; dones = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (pulse === 1'b1) highs++;
            if (busy === 1'b1) busies++;
            if (done === 1'b1) dones++;
        end
        check("max period high cycles", highs, 254);
        check("max period busy cycles", busies, 255);
        check("max period done", dones, 1);
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of a pulse, start held through it
        cfg(5, 10, 1);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset pulse_o", pulse, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset pulse_o", pulse, 0);
        check("async reset busy_o",  busy,  0);
        check("async reset done_o",  done,  0);
`ifdef PULSE_TRAIN_GEN_LED_EN
        check("async reset led_busy_n_o", led_n, 1);
`endif
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0; busies = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busies++;
        end
        check("post-reset no done", dones, 0);
        check("post-reset held start no train", busies, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_pulse_train_gen

`default_nettype wire

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of the pulse width and period counters.
REQ-002 SHALL have parameter NUM_W, default 16, meaning the width of the pulse-count field.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start_i, input, 1 bit: level input, synchronous to clk_i; its rising edge requests a train.
REQ-006 SHALL have port stop_i, input, 1 bit: level input, synchronous to clk_i; aborts a train.
REQ-007 SHALL have port width_i, input, CNT_W bits: high time in clk_i cycles.
REQ-008 SHALL have port period_i, input, CNT_W bits: rising-edge-to-rising-edge time in clk_i cycles.
REQ-009 SHALL have port count_i, input, NUM_W bits: number of pulses; 0 means continuous.
REQ-010 SHALL have port pulse_o, output, 1 bit: registered, positive-logic stimulus to the channel under test.
REQ-011 SHALL have port busy_o, output, 1 bit: high while a train runs.
REQ-012 SHALL have port done_o, output, 1 bit: single-cycle strobe marking train completion or abort.
REQ-013 SHALL have port err_o, output, 1 bit: single-cycle strobe marking a rejected configuration.

Function
REQ-014 SHALL implement states IDLE, HIGH, LOW, DONE.
REQ-015 SHALL detect a start as start_i=1 at the current edge with start_i=0 at the previous edge; a level held high SHALL NOT retrigger.
REQ-016 In IDLE, on a start, SHALL latch width_i, period_i and count_i.
REQ-017 In IDLE, on a start with width_i==0 or width_i>=period_i, SHALL pulse err_o for 1 cycle and remain in IDLE.
REQ-018 A valid start at edge k SHALL drive pulse_o=1 and busy_o=1 from cycle k+1, entering HIGH.
REQ-019 In HIGH, pulse_o SHALL be 1 for exactly width cycles, then the block SHALL enter LOW.
REQ-020 In LOW, pulse_o SHALL be 0 for exactly period-width cycles, giving a period of exactly period cycles.
REQ-021 At the end of LOW, SHALL decrement the remaining count, then go to HIGH if the count is nonzero or continuous mode is active, else to DONE.
REQ-022 In DONE, SHALL set done_o=1, busy_o=0 and pulse_o=0 for 1 cycle, then go to IDLE.
REQ-023 stop_i=1 in HIGH or LOW SHALL force pulse_o=0 on the next cycle and enter DONE, truncating the current pulse.
REQ-024 stop_i and a start at the same edge in IDLE: stop SHALL win and the start SHALL be ignored.
REQ-025 A start while busy_o=1 SHALL be ignored, and SHALL NOT be queued.
REQ-026 Input changes while busy_o=1 SHALL NOT affect the running train.
REQ-027 Counters SHALL use CNT_W bits and never wrap: width and period are compared with >=, and a value of 2^CNT_W-1 is legal.

Reset
REQ-028 Assertion of reset_n_i=0 SHALL immediately set pulse_o=0, busy_o=0, done_o=0, err_o=0, all counters to 0, state to IDLE and the previous-start register to 1.
REQ-029 After reset is released with start_i already high, SHALL NOT start a train.
REQ-030 Reset asserted mid-train SHALL abort it without a done_o strobe.

Configuration
REQ-031 With PULSE_TRAIN_GEN_LED_EN defined, SHALL add output led_busy_n_o, 1 bit, equal to registered ~busy_o (active-low LED drive), reset value 1.
REQ-032 Without PULSE_TRAIN_GEN_LED_EN, the port and its logic SHALL be absent.

Structure
REQ-033 Package pulse_gen_pkg SHALL hold the state enum pulse_gen_state_t and the default constants CNT_W_DEF=32 and NUM_W_DEF=16.
REQ-034 Start detection SHALL be a sub-module named pulse_rise_det (registered previous value, combinational strobe, reset value 1).

Verification
REQ-035 Bench SHALL cover: width=3, period=10, count=2, start at edge 5 -> pulse_o high cycles 6-8 and 16-18; done_o at cycle 26; busy_o high cycles 6-25.
REQ-036 Bench SHALL cover: width=0 or width=10/period=10 start -> err_o 1 cycle; pulse_o and busy_o stay 0.
REQ-037 Bench SHALL cover: count=0, width=2, period=4 -> continuous 50% train; stop_i in HIGH -> pulse_o 0 next cycle; done_o 1 cycle later.
REQ-038 Bench SHALL cover: start_i held high for 100 cycles with count=1 -> exactly one pulse.
REQ-039 Bench SHALL cover: second start mid-train, and start plus stop together in IDLE -> no effect in either case.
REQ-040 Bench SHALL cover: reset_n_i pulsed low mid-HIGH -> outputs 0 asynchronously, no done_o; LED variant -> led_busy_n_o=1.
